// File: rtl/debouncer_pkg.sv
// Shared definitions for the debouncer.
// Holds the counter-width helper used by the top.
package debouncer_pkg;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Debounces a synchronized level and emits rise/fall strobes.
// data_out changes after STABLE_CYCLES consecutive differing samples.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1) begin : g_bad_param
    $error("debouncer: STABLE_CYCLES must be >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          data_out_q, data_out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    if (data_in == data_out_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      // Last of the required differing samples: commit and strobe.
      data_out_d = data_in;
      cnt_d      = '0;
      rise_d     = data_in;
      fall_d     = ~data_in;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      data_out_q <= RESET_VALUE;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign data_out = data_out_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed self-checking bench for debouncer.
// Runs STABLE_CYCLES=4 and STABLE_CYCLES=1 instances side by side.
module tb_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic out4, rise4, fall4;
  logic out1, rise1, fall1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debouncer #(.STABLE_CYCLES(4), .RESET_VALUE(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .data_in(din),
    .data_out(out4), .rise(rise4), .fall(fall4)
  );

  debouncer #(.STABLE_CYCLES(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(din),
    .data_out(out1), .rise(rise1), .fall(fall1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v);
    din = v;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    din = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out4, rise4, fall4} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold[%0d] got=%b exp=000", i,
                 {out4, rise4, fall4});
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({out4, rise4, fall4} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release got=%b exp=000", {out4, rise4, fall4});
    end
    exp = 3'b110;
    n_cmp++;
    if ({out1, rise1, fall1} !== exp) begin
      n_err++;
      $display("FAIL reset_release_sc1 got=%b exp=%b",
               {out1, rise1, fall1}, exp);
    end
  endtask

  task automatic test_clean_rise();
    logic [2:0] exp;
    do_reset(1'b0);
    din = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i < 4) ? 3'b000 : (i == 4) ? 3'b110 : 3'b100;
      n_cmp++;
      if ({out4, rise4, fall4} !== exp) begin
        n_err++;
        $display("FAIL clean_rise[%0d] got=%b exp=%b", i,
                 {out4, rise4, fall4}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] exp;
    int rises;
    rises = 0;
    do_reset(1'b0);
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      rises += int'(rise4);
    end
    din = 1'b0;
    tick();
    rises += int'(rise4);
    n_cmp++;
    if (out4 !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_hold got=%b exp=0", out4);
    end
    din = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      rises += int'(rise4);
      exp = (i < 4) ? 3'b000 : (i == 4) ? 3'b110 : 3'b100;
      n_cmp++;
      if ({out4, rise4, fall4} !== exp) begin
        n_err++;
        $display("FAIL glitch[%0d] got=%b exp=%b", i,
                 {out4, rise4, fall4}, exp);
      end
    end
    n_cmp++;
    if (rises !== 1) begin
      n_err++;
      $display("FAIL glitch_rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_clean_fall();
    logic [2:0] exp;
    din = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i < 4) ? 3'b100 : (i == 4) ? 3'b001 : 3'b000;
      n_cmp++;
      if ({out4, rise4, fall4} !== exp) begin
        n_err++;
        $display("FAIL clean_fall[%0d] got=%b exp=%b", i,
                 {out4, rise4, fall4}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    logic [2:0] exp;
    do_reset(1'b0);
    din = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({out4, rise4, fall4} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_pending_rst got=%b exp=000", {out4, rise4, fall4});
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i < 4) ? 3'b000 : (i == 4) ? 3'b110 : 3'b100;
      n_cmp++;
      if ({out4, rise4, fall4} !== exp) begin
        n_err++;
        $display("FAIL mid_pending[%0d] got=%b exp=%b", i,
                 {out4, rise4, fall4}, exp);
      end
    end
  endtask

  task automatic test_toggle();
    logic v;
    logic [2:0] exp1;
    int bad4, bad1;
    bad4 = 0;
    bad1 = 0;
    do_reset(1'b0);
    for (int i = 0; i < 50; i++) begin
      v = (i % 2 == 0);
      din = v;
      tick();
      exp1 = {v, v, ~v};
      if ({out4, rise4, fall4} !== 3'b000) bad4++;
      if ({out1, rise1, fall1} !== exp1) bad1++;
    end
    n_cmp++;
    if (bad4 !== 0) begin
      n_err++;
      $display("FAIL toggle_sc4 bad_cycles got=%0d exp=0", bad4);
    end
    n_cmp++;
    if (bad1 !== 0) begin
      n_err++;
      $display("FAIL toggle_sc1 bad_cycles got=%0d exp=0", bad1);
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_clean_fall();
    test_reset_mid_pending();
    test_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
